vgm_wb_slave_regfile: RTL and testbench

VGM_WB_SLAVE_REGFILE -- requirements
Module: vgm_wb_slave_regfile

---
 rtl/vgm_wb_pkg.sv | 19 +
 rtl/vgm_wb_regfile_mem.sv | 37 +++
 rtl/vgm_wb_slave_regfile.sv | 120 ++++++++++++
 tb/tb_vgm_wb_slave_regfile.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vgm_wb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vgm_wb_pkg
// Brief  : Shared Wishbone widths and handshake FSM state type.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package vgm_wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/vgm_wb_regfile_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vgm_wb_regfile_mem
// Brief  : NUM_REGS x 32 register array, one write port, one async read port.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module vgm_wb_regfile_mem
  import vgm_wb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_waddr,
  input  logic [WB_DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]     i_raddr,
  output logic [WB_DATA_W-1:0] o_rdata
);

  logic [WB_DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/vgm_wb_slave_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vgm_wb_slave_regfile
// Brief  : Wishbone classic slave with programmable wait states over a regfile.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module vgm_wb_slave_regfile
  import vgm_wb_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 CYC_I,
  input  logic                 STB_I,
  input  logic                 WE_I,
  input  logic [WB_ADDR_W-1:0] ADR_I,
  input  logic [WB_DATA_W-1:0] DAT_I,
  output logic                 ACK_O,
  output logic [WB_DATA_W-1:0] DAT_O
);

  localparam int         c_idx_w     = $clog2(NUM_REGS);
  localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  wb_state_t              r_state;
  wb_state_t              w_state_nxt;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic                   r_we;
  logic [c_idx_w-1:0]     r_idx;
  logic [WB_DATA_W-1:0]   r_dat;

  logic                   w_req;
  logic                   w_accept;
  logic [c_idx_w-1:0]     w_adr_idx;
  logic                   w_mem_we;
  logic [c_idx_w-1:0]     w_mem_idx;
  logic [WB_DATA_W-1:0]   w_mem_wdata;
  logic [WB_DATA_W-1:0]   w_rdata;
  logic                   w_unused_adr;

  assign w_req     = CYC_I & STB_I;
  assign w_adr_idx = ADR_I[c_idx_w+1:2];
  // Upper address bits alias onto the index field; byte lanes are ignored.
  assign w_unused_adr = ^{ADR_I[WB_ADDR_W-1:c_idx_w+2], ADR_I[1:0]};

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we  <= WE_I;
        r_idx <= w_adr_idx;
        r_dat <= DAT_I;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = c_wait_load;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Commit on the edge entering ACK; with zero wait states that is the capture edge.
  assign w_mem_we    = (w_state_nxt == ST_ACK) && (w_accept ? WE_I : r_we);
  assign w_mem_idx   = w_accept ? w_adr_idx : r_idx;
  assign w_mem_wdata = w_accept ? DAT_I : r_dat;

  vgm_wb_regfile_mem #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (c_idx_w)
  ) u_mem (
    .clk     (CLK_I),
    .rst     (RST_I),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_idx),
    .i_wdata (w_mem_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  assign ACK_O = (r_state == ST_ACK);
  assign DAT_O = (r_state == ST_ACK) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_vgm_wb_slave_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_vgm_wb_slave_regfile
// Brief  : Scoreboard bench driving a zero-wait and a three-wait-state slave.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_vgm_wb_slave_regfile;

  localparam int NREGS = 16;
  localparam int W0    = 0;
  localparam int W1    = 3;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [31:0] adr   [2];
  logic [31:0] dat_i [2];
  logic        ack   [2];
  logic [31:0] dat_o [2];

  vgm_wb_slave_regfile #(.NUM_REGS(NREGS), .WAIT_CYCLES(W0)) dut0 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]),
    .ADR_I(adr[0]), .DAT_I(dat_i[0]), .ACK_O(ack[0]), .DAT_O(dat_o[0])
  );

  vgm_wb_slave_regfile #(.NUM_REGS(NREGS), .WAIT_CYCLES(W1)) dut1 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]),
    .ADR_I(adr[1]), .DAT_I(dat_i[1]), .ACK_O(ack[1]), .DAT_O(dat_o[1])
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [31:0] model [2][NREGS];
  exp_t        q0[$];
  exp_t        q1[$];
  bit          done   = 1'b0;
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic int wc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Every task is entered and left just after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; adr[d] = a; dat_i[d] = wd;
    e.rd  = !wr;
    e.cyc = cyc_cnt + 1 + wc(d);
    if (wr) model[d][idx_of(a)] = wd;
    e.data = model[d][idx_of(a)];
    push(d, e);
    @(posedge clk); #1;
    we[d] = 1'($urandom); adr[d] = $urandom; dat_i[d] = $urandom;
    for (int i = 0; i < wc(d) + 4; i++) begin
      @(negedge clk);
      if (ack[d]) break;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic abort_xfer(input int d, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input int k, input bit use_rst);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; adr[d] = a; dat_i[d] = wd;
    @(posedge clk); #1;
    repeat (k) begin @(posedge clk); #1; end
    if (use_rst) begin
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      for (int j = 0; j < 2; j++) begin
        cyc[j] = 1'b0; stb[j] = 1'b0;
        for (int i = 0; i < NREGS; i++) model[j][i] = '0;
      end
      rst = 1'b0;
    end else begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
      repeat (wc(d) + 3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic burst(input int d, input logic [31:0] a);
    exp_t e;
    int   pulses;
    pulses = 0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = a;
    for (int p = 0; p < 3; p++) begin
      e.rd   = 1'b1;
      e.data = model[d][idx_of(a)];
      e.cyc  = cyc_cnt + 1 + wc(d) + p * (wc(d) + 2);
      push(d, e);
    end
    for (int i = 0; i < 3 * (wc(d) + 2) + 4; i++) begin
      @(negedge clk);
      if (ack[d]) begin
        pulses++;
        if (pulses == 3) break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_one(input int d);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (ack[d]) begin
      n_cmp++;
      if (!have) begin
        n_fail++;
        $display("FAIL unexpected_ack dut%0d cycle %0d: ACK_O=1, required 0 (nothing outstanding)", d, cyc_cnt);
      end else begin
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        if (cyc_cnt != e.cyc) begin
          n_fail++;
          $display("FAIL ack_cycle dut%0d: ACK_O at cycle %0d, required cycle %0d", d, cyc_cnt, e.cyc);
        end
        if (e.rd) begin
          n_cmp++;
          if (dat_o[d] !== e.data) begin
            n_fail++;
            $display("FAIL read_data dut%0d cycle %0d: DAT_O=%h, required %h", d, cyc_cnt, dat_o[d], e.data);
          end
        end
      end
    end else begin
      n_cmp++;
      if (dat_o[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL dat_o_idle dut%0d cycle %0d: DAT_O=%h, required 0", d, cyc_cnt, dat_o[d]);
      end
      if (have && cyc_cnt >= e.cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missing_ack dut%0d: ACK_O=0 at cycle %0d, required 1 at cycle %0d", d, cyc_cnt, e.cyc);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    check_one(0);
    check_one(1);
    if (done || cyc_cnt > 60000) begin
      if (!done) begin
        n_fail++;
        $display("FAIL watchdog: stimulus unfinished at cycle %0d, required done", cyc_cnt);
      end
      n_cmp++;
      if (q0.size() + q1.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_expect: %0d responses outstanding, required 0", q0.size() + q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; dat_i[d] = '0;
      for (int i = 0; i < NREGS; i++) model[d][i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // First request straight after reset release, read of a cleared register
    xfer(1, 1'b0, 32'h0000_0000, 32'h0);
    xfer(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h0000_0004, 32'h0);
    // Write abandoned one wait cycle in must leave the register untouched
    abort_xfer(1, 1'b1, 32'h0000_0008, 32'h1234_5678, 1, 1'b0);
    xfer(1, 1'b0, 32'h0000_0008, 32'h0);
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5);
      xfer(d, 1'b0, 32'h0000_0000, 32'h0);
    end
    // Reset during the wait phase of a write
    abort_xfer(1, 1'b1, 32'h0000_000C, 32'h0000_0001, 1, 1'b1);
    xfer(1, 1'b0, 32'h0000_000C, 32'h0);
    xfer(0, 1'b0, 32'h0000_0000, 32'h0);
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 32'h0000_0014, $urandom);
      burst(d, 32'h0000_0014);
    end
    // Cycle open but no strobe: nothing may be acknowledged
    for (int d = 0; d < 2; d++) cyc[d] = 1'b1;
    repeat (6) begin
      for (int d = 0; d < 2; d++) begin adr[d] = $urandom; we[d] = 1'($urandom); end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) cyc[d] = 1'b0;

    for (int n = 0; n < 200; n++) begin
      int          d;
      bit          wr;
      logic [31:0] a;
      logic [31:0] wd;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      a  = $urandom;
      wd = $urandom;
      if (d == 1 && $urandom_range(0, 5) == 0)
        abort_xfer(1, wr, a, wd, int'($urandom_range(0, W1 - 1)), 1'b0);
      else if ($urandom_range(0, 9) == 0)
        burst(d, a);
      else
        xfer(d, wr, a, wd);
    end

    repeat (6) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
`default_nettype wire
